// File: rtl/mux2x1_rr_stream.sv
// ---------------------------------------------------------------------------
// mux2x1_rr_stream
//
// Registered two-input stream merger with round-robin arbitration.
// It takes words from two valid/ready sources and holds the winning word in a
// single output register. It also drives y_sel, which names the source of the
// held word so that downstream 2:1 muxes can be steered alongside it.
// Throughput is one word per cycle: a FULL register that is consumed and
// refilled in the same cycle produces no bubble.
//
// Ports
//   clk       in   1      rising-edge clock
//   rst       in   1      asynchronous active-high reset
//   a0        in   WIDTH  source 0 data
//   a0_valid  in   1      source 0 holds a word
//   a0_ready  out  1      source 0 word accepted this cycle if a0_valid
//   a1        in   WIDTH  source 1 data
//   a1_valid  in   1      source 1 holds a word
//   a1_ready  out  1      source 1 word accepted this cycle if a1_valid
//   y         out  WIDTH  registered output word
//   y_valid   out  1      y holds a word
//   y_ready   in   1      consumer takes y this cycle if y_valid
//   y_sel     out  1      source index of the held word (0 = a0, 1 = a1)
// ---------------------------------------------------------------------------
module mux2x1_rr_stream #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a0,
    input  logic             a0_valid,
    output logic             a0_ready,
    input  logic [WIDTH-1:0] a1,
    input  logic             a1_valid,
    output logic             a1_ready,
    output logic [WIDTH-1:0] y,
    output logic             y_valid,
    input  logic             y_ready,
    output logic             y_sel
);

    // Occupancy of the single output register.
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] y_q;
    logic             sel_q;
    logic             pri_q;   // favoured source: 0 = a0, 1 = a1
    logic             load;
    logic             gnt0;
    logic             gnt1;

    // -----------------------------------------------------------------------
    // Arbitration and next-state logic
    // -----------------------------------------------------------------------
    // NOTE: every signal driven here is assigned before any branch, so no path
    // leaves a value unassigned and no latch can be inferred.
    always_comb begin
        // The register can accept a word when it is empty or when its current
        // word leaves this cycle.
        load     = (state_q == EMPTY) | y_ready;

        // A source is offered ready when the register can load and the other
        // source is either idle or not favoured. The readies never look at the
        // source's own valid, so there is no valid->ready loop. The two readies
        // can both be high only when at most one source is valid, which means
        // at most one grant happens per cycle.
        a0_ready = load & (~a1_valid | ~pri_q);
        a1_ready = load & (~a0_valid |  pri_q);

        gnt0     = a0_valid & a0_ready;
        gnt1     = a1_valid & a1_ready;

        state_d  = state_q;
        if (gnt0 | gnt1) begin
            // Loading takes priority over draining: a consume and a load in the
            // same cycle keep the register FULL.
            state_d = FULL;
        end else if ((state_q == FULL) && y_ready) begin
            state_d = EMPTY;
        end
    end

    // -----------------------------------------------------------------------
    // Occupancy register
    // -----------------------------------------------------------------------
    // NOTE: state is updated with non-blocking assignments so that every
    // register samples the values from before the edge, whatever the order in
    // which the always blocks are evaluated.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // -----------------------------------------------------------------------
    // Held word, its source index and the priority pointer
    // -----------------------------------------------------------------------
    // NOTE: the data register is reset as well, because y must read as zero
    // from the moment reset is asserted. It is a single word, not a memory
    // array, so the reset costs only one flop input per bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y_q   <= '0;
            sel_q <= 1'b0;
            pri_q <= 1'b0;
        end else if (gnt0) begin
            y_q   <= a0;
            sel_q <= 1'b0;
            pri_q <= 1'b1;  // source 0 just had its turn
        end else if (gnt1) begin
            y_q   <= a1;
            sel_q <= 1'b1;
            pri_q <= 1'b0;  // source 1 just had its turn
        end
        // When there is no transfer, y, y_sel and pri hold. This covers the
        // drain to EMPTY, because a consumed word stays visible on y.
    end

    assign y       = y_q;
    assign y_valid = (state_q == FULL);
    assign y_sel   = sel_q;

endmodule
